// File: rtl/vic_raster_timing.sv
// VIC-II style raster beam timing: dot/line counters, CPU cycle + phi0, bad-line detect, raster IRQ.
// Define VIC_RASTER_IRQ_EN to compile in the raster compare interrupt; otherwise irq is tied low.
module vic_raster_timing #(
  parameter int CYCLES_PER_LINE = 63,
  parameter int LINES_PER_FRAME = 312
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic       den,
  input  logic [2:0] yscroll,
  input  logic [8:0] raster_cmp,
  input  logic       irq_en,
  input  logic       irq_ack,
  output logic [9:0] xpos,
  output logic [8:0] raster,
  output logic [5:0] cycle,
  output logic       phi0,
  output logic       line_start,
  output logic       frame_start,
  output logic       bad_line,
  output logic       irq
);

  localparam logic [9:0] XMAX = 10'(CYCLES_PER_LINE * 8 - 1);
  localparam logic [8:0] RMAX = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] DEN_LINE   = 9'h030;
  localparam logic [8:0] BAD_FIRST  = 9'h030;
  localparam logic [8:0] BAD_LAST   = 9'h0F7;

  logic       x_wrap, r_wrap;
  logic [9:0] xpos_nxt;
  logic [8:0] raster_nxt;
  logic       den_lat;

  assign x_wrap = (xpos == XMAX);
  assign r_wrap = (raster == RMAX);

  always_comb begin
    xpos_nxt   = x_wrap ? 10'd0 : xpos + 10'd1;
    raster_nxt = raster;
    if (x_wrap)
      raster_nxt = r_wrap ? 9'd0 : raster + 9'd1;
  end

  // cycle/phi0 are computed from the next dot position so they track xpos with no extra latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xpos        <= '0;
      raster      <= '0;
      cycle       <= 6'd1;
      phi0        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= dot_en & x_wrap;
      frame_start <= dot_en & x_wrap & r_wrap;
      if (dot_en) begin
        xpos   <= xpos_nxt;
        raster <= raster_nxt;
        cycle  <= xpos_nxt[8:3] + 6'd1;
        phi0   <= xpos_nxt[2];
      end
    end
  end

  // DEN is only sampled on line $30; the latch holds the decision for the rest of the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      den_lat <= 1'b0;
    else if (raster == DEN_LINE && den)
      den_lat <= 1'b1;
    else if (dot_en && x_wrap && r_wrap)
      den_lat <= 1'b0;
  end

  assign bad_line = (raster >= BAD_FIRST) && (raster <= BAD_LAST) &&
                    (raster[2:0] == yscroll) &&
                    (den_lat || (raster == DEN_LINE && den));

`ifdef VIC_RASTER_IRQ_EN
  logic irq_flag;
  logic irq_set;

  // compare only on entry to a new line, so rewriting raster_cmp mid-line cannot fire
  assign irq_set = dot_en & x_wrap & (raster_nxt == raster_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_flag <= 1'b0;
    else
      irq_flag <= irq_set | (irq_flag & ~irq_ack);
  end

  assign irq = irq_flag & irq_en;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{raster_cmp, irq_en, irq_ack};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vic_raster_timing.sv
// Bench for vic_raster_timing: a full-size instance plus a short-line instance (8 cycles/line)
// so a complete frame fits in a short run; both share stimulus and are checked every cycle.
module tb_vic_raster_timing;
  localparam int CPL_A = 63;
  localparam int CPL_S = 8;
  localparam int LPF   = 312;
`ifdef VIC_RASTER_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic       clk = 0, reset = 0, dot_en = 0, den = 0, irq_en = 0, irq_ack = 0;
  logic [2:0] yscroll = 0;
  logic [8:0] raster_cmp = 0;

  logic [9:0] xpos_a, xpos_s;
  logic [8:0] raster_a, raster_s;
  logic [5:0] cycle_a, cycle_s;
  logic       phi0_a, phi0_s, ls_a, ls_s, fs_a, fs_s, bl_a, bl_s, irq_a, irq_s;

  vic_raster_timing #(.CYCLES_PER_LINE(CPL_A), .LINES_PER_FRAME(LPF)) dut (
    .clk(clk), .reset(reset), .dot_en(dot_en), .den(den), .yscroll(yscroll),
    .raster_cmp(raster_cmp), .irq_en(irq_en), .irq_ack(irq_ack),
    .xpos(xpos_a), .raster(raster_a), .cycle(cycle_a), .phi0(phi0_a),
    .line_start(ls_a), .frame_start(fs_a), .bad_line(bl_a), .irq(irq_a));

  vic_raster_timing #(.CYCLES_PER_LINE(CPL_S), .LINES_PER_FRAME(LPF)) dut_s (
    .clk(clk), .reset(reset), .dot_en(dot_en), .den(den), .yscroll(yscroll),
    .raster_cmp(raster_cmp), .irq_en(irq_en), .irq_ack(irq_ack),
    .xpos(xpos_s), .raster(raster_s), .cycle(cycle_s), .phi0(phi0_s),
    .line_start(ls_s), .frame_start(fs_s), .bad_line(bl_s), .irq(irq_s));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: t = dot ticks since reset; everything positional is derived from it arithmetically.
  int t = 0;
  bit ls_m[2], fs_m[2], fl_m[2], dl_m[2];

  function automatic int cpl_of(int i);
    return (i == 0) ? CPL_A : CPL_S;
  endfunction
  function automatic int m_x(int tt, int cpl);
    return tt % (cpl * 8);
  endfunction
  function automatic int m_r(int tt, int cpl);
    return (tt / (cpl * 8)) % LPF;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t <= 0;
      for (int i = 0; i < 2; i++) begin
        ls_m[i] <= 0; fs_m[i] <= 0; fl_m[i] <= 0; dl_m[i] <= 0;
      end
    end else begin
      if (dot_en) t <= t + 1;
      for (int i = 0; i < 2; i++) begin
        ls_m[i] <= dot_en && (m_x(t + 1, cpl_of(i)) == 0);
        fs_m[i] <= dot_en && ((t + 1) % (cpl_of(i) * 8 * LPF) == 0);
        fl_m[i] <= (dot_en && m_x(t + 1, cpl_of(i)) == 0 && m_r(t + 1, cpl_of(i)) == int'(raster_cmp))
                   || (fl_m[i] && !irq_ack);
        dl_m[i] <= (m_r(t, cpl_of(i)) == 48 && den)
                   || (dl_m[i] && !(dot_en && ((t + 1) % (cpl_of(i) * 8 * LPF) == 0)));
      end
    end
  end

  function automatic logic [29:0] exp_vec(int i);
    int  x = m_x(t, cpl_of(i));
    int  r = m_r(t, cpl_of(i));
    logic b = (r >= 48) && (r <= 247) && ((r % 8) == int'(yscroll)) && (dl_m[i] || (r == 48 && den));
    logic q = (IRQ_ON != 0) && fl_m[i] && irq_en;
    return {10'(x), 9'(r), 6'(x / 8 + 1), 1'((x >> 2) & 1), ls_m[i], fs_m[i], b, q};
  endfunction

  wire [29:0] got_a = {xpos_a, raster_a, cycle_a, phi0_a, ls_a, fs_a, bl_a, irq_a};
  wire [29:0] got_s = {xpos_s, raster_s, cycle_s, phi0_s, ls_s, fs_s, bl_s, irq_s};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [29:0] e, g;
      e = exp_vec(i);
      g = (i == 0) ? got_a : got_s;
      n_chk++;
      if (g === e) n_pass++;
      else $display("FAIL model_%s t=%0d got x=%0d r=%0d cyc=%0d phi/ls/fs/bl/irq=%b expected x=%0d r=%0d cyc=%0d phi/ls/fs/bl/irq=%b",
                    (i == 0) ? "full" : "short", t, g[29:20], g[19:11], g[10:5], g[4:0],
                    e[29:20], e[19:11], e[10:5], e[4:0]);
    end
  end

  task automatic chk(input string nm, input int got, input int exp_v);
    n_chk++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    dot_en = 1;
    while (t < target && guard < 60000) begin
      step();
      guard++;
    end
    dot_en = 0;
    if (guard >= 60000) chk("run_to_timeout", t, target);
  endtask

  initial begin
    #1 reset = 1;
    #2;
    chk("rst_xpos", int'(xpos_a), 0);
    chk("rst_raster", int'(raster_a), 0);
    chk("rst_cycle", int'(cycle_a), 1);
    chk("rst_phi0", int'(phi0_a), 0);
    chk("rst_irq", int'(irq_a), 0);
    step();
    reset = 0;
    den = 1; yscroll = 3'd3; raster_cmp = 9'h100; irq_en = 1;

    // first line
    run_to(503);
    chk("cycle_63", int'(cycle_a), 63);
    chk("xpos_503", int'(xpos_a), 503);
    chk("ls_before_wrap", int'(ls_a), 0);
    run_to(504);
    chk("xpos_wrap", int'(xpos_a), 0);
    chk("raster_1", int'(raster_a), 1);
    chk("ls_pulse", int'(ls_a), 1);
    step();
    chk("ls_one_clk", int'(ls_a), 0);

    // slow dot rate, then a 20-clk hold
    run_to(512);
    chk("slow_x0", int'(xpos_a), 8);
    chk("slow_phi0_lo", int'(phi0_a), 0);
    for (int k = 1; k <= 8; k++) begin
      dot_en = 1; step(); dot_en = 0;
      if (k == 4) begin
        chk("slow_x4", int'(xpos_a), 12);
        chk("slow_phi0_hi", int'(phi0_a), 1);
        chk("slow_cyc4", int'(cycle_a), 2);
      end
      repeat (7) step();
    end
    chk("slow_x8", int'(xpos_a), 16);
    chk("slow_phi0_lo2", int'(phi0_a), 0);
    chk("slow_cyc8", int'(cycle_a), 3);
    repeat (20) step();
    chk("hold_xpos", int'(xpos_a), 16);
    chk("hold_raster", int'(raster_a), 1);
    chk("hold_cycle", int'(cycle_a), 3);
    chk("hold_phi0", int'(phi0_a), 0);

    // bad lines on the short instance, yscroll=3
    run_to(51 * 64 + 5);
    chk("bl_33", int'(bl_s), 1);
    run_to(52 * 64 + 5);
    chk("bl_34", int'(bl_s), 0);
    run_to(59 * 64 + 5);
    chk("bl_3b", int'(bl_s), 1);
    run_to(243 * 64 + 5);
    chk("bl_f3", int'(bl_s), 1);
    run_to(251 * 64 + 5);
    chk("bl_fb", int'(bl_s), 0);

    // raster IRQ at line 256
    run_to(256 * 64 - 1);
    chk("irq_pre256", int'(irq_s), 0);
    run_to(256 * 64);
    chk("raster_256", int'(raster_s), 256);
    chk("irq_256_ls", int'(ls_s), 1);
    chk("irq_256", int'(irq_s), IRQ_ON);
    irq_ack = 1; run_to(256 * 64 + 1); irq_ack = 0;
    chk("irq_acked", int'(irq_s), 0);
    raster_cmp = 9'h101;
    run_to(256 * 64 + 63);
    irq_ack = 1; run_to(257 * 64); irq_ack = 0;
    chk("irq_set_vs_ack", int'(irq_s), IRQ_ON);
    irq_ack = 1; run_to(257 * 64 + 1); irq_ack = 0;
    chk("irq_acked2", int'(irq_s), 0);
    raster_cmp = 9'h101;
    run_to(257 * 64 + 12);
    chk("irq_cmp_midline", int'(irq_s), 0);
    irq_en = 0; raster_cmp = 9'h102;
    run_to(258 * 64);
    chk("irq_masked", int'(irq_s), 0);
    irq_en = 1; #1;
    chk("irq_unmasked", int'(irq_s), IRQ_ON);
    irq_ack = 1; step(); irq_ack = 0;

    // frame wrap on the short instance; den off so the next frame has no bad lines
    den = 0;
    run_to(312 * 64 - 1);
    chk("fs_pre", int'(fs_s), 0);
    run_to(312 * 64);
    chk("fs_pulse", int'(fs_s), 1);
    chk("fs_ls", int'(ls_s), 1);
    chk("fs_raster0", int'(raster_s), 0);
    step();
    chk("fs_one_clk", int'(fs_s), 0);
    run_to(312 * 64 + 51 * 64 + 5);
    chk("f2_raster_33", int'(raster_s), 51);
    chk("bl_latch_clear", int'(bl_s), 0);

    // den back on before the full-size instance reaches line $30
    den = 1;
    run_to(51 * 504 + 5);
    chk("full_raster_33", int'(raster_a), 51);
    chk("full_bl_33", int'(bl_a), 1);

    // reset mid-line with irq pending
    raster_cmp = 9'd100;
    run_to(100 * 504 + 250);
    chk("pre_rst_xpos", int'(xpos_a), 250);
    chk("pre_rst_raster", int'(raster_a), 100);
    chk("pre_rst_irq", int'(irq_a), IRQ_ON);
    reset = 1; #1;
    chk("arst_xpos", int'(xpos_a), 0);
    chk("arst_raster", int'(raster_a), 0);
    chk("arst_cycle", int'(cycle_a), 1);
    chk("arst_phi0", int'(phi0_a), 0);
    chk("arst_ls", int'(ls_a), 0);
    chk("arst_fs", int'(fs_a), 0);
    chk("arst_irq", int'(irq_a), 0);
    chk("arst_bl", int'(bl_a), 0);
    step(); step();
    reset = 0;
    run_to(1);
    chk("post_rst_xpos", int'(xpos_a), 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vic_raster_timing.md
VIC_RASTER_TIMING -- requirements
Module: vic_raster_timing

Interface
REQ-001 SHALL provide parameter CYCLES_PER_LINE, default 63, meaning CPU cycles per raster line (PAL 6569).
REQ-002 SHALL provide parameter LINES_PER_FRAME, default 312, meaning raster lines per frame (PAL 6569).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dot_en  input  1  one-clk pixel tick; counters advance only when high.
REQ-006 SHALL have port den  input  1  display enable (DEN bit).
REQ-007 SHALL have port yscroll  input  3  vertical fine scroll.
REQ-008 SHALL have port raster_cmp  input  9  raster IRQ compare line.
REQ-009 SHALL have port irq_en  input  1  raster IRQ mask.
REQ-010 SHALL have port irq_ack  input  1  one-clk pulse clearing the raster IRQ flag.
REQ-011 SHALL have port xpos  output  10  dot position in line, 0..CYCLES_PER_LINE*8-1.
REQ-012 SHALL have port raster  output  9  current raster line, 0..LINES_PER_FRAME-1.
REQ-013 SHALL have port cycle  output  6  CPU cycle in line, 1..CYCLES_PER_LINE.
REQ-014 SHALL have port phi0  output  1  CPU clock derived from dot position.
REQ-015 SHALL have port line_start  output  1  one-clk pulse on line wrap.
REQ-016 SHALL have port frame_start  output  1  one-clk pulse on frame wrap.
REQ-017 SHALL have port bad_line  output  1  bad-line condition for current line.
REQ-018 SHALL have port irq  output  1  raster interrupt request, active-high.

Function
REQ-019 On clk with dot_en=1, xpos SHALL increment by 1; at CYCLES_PER_LINE*8-1 (503) it SHALL wrap to 0; dot_en=0 SHALL hold all state.
REQ-020 On xpos wrap, raster SHALL increment; at LINES_PER_FRAME-1 (311) it SHALL wrap to 0 in the same clk.
REQ-021 cycle SHALL be registered and equal (new xpos>>3)+1 in the same clk xpos updates (zero added latency).
REQ-022 phi0 SHALL be registered, 0 while new xpos[2]=0 and 1 while new xpos[2]=1 (4 dots low, 4 dots high per cycle).
REQ-023 line_start SHALL be 1 for exactly the clk following an xpos wrap, else 0; frame_start SHALL be 1 only when the wrap also wraps raster.
REQ-024 A den latch SHALL set when raster=0x30 and den=1 at any clk of that line, and clear when raster wraps to 0.
REQ-025 bad_line SHALL be 1 iff raster in 0x30..0xF7, raster[2:0]=yscroll and den latch (or den during line 0x30) is 1; it SHALL be combinational over registered state and inputs.
REQ-026 When the line counter transitions into a line equal to raster_cmp (including wrap to 0), the IRQ flag SHALL set in the same clk as line_start.
REQ-027 irq_ack=1 SHALL clear the flag on the next edge; simultaneous set and ack SHALL leave the flag set.
REQ-028 irq SHALL equal flag AND irq_en; changing raster_cmp mid-line SHALL not set the flag.
REQ-029 Arithmetic SHALL not overflow: counters compare against parameter limits, never rely on natural wrap.

Reset
REQ-030 reset=1 SHALL immediately force xpos=0, raster=0, cycle=1, phi0=0, line_start=0, frame_start=0, den latch=0, IRQ flag=0, irq=0.
REQ-031 Reset mid-line SHALL abandon the line; first dot_en after release SHALL give xpos=1.

Configuration
REQ-032 Macro VIC_RASTER_IRQ_EN defined: IRQ flag, compare and ack logic per REQ-026..028 SHALL be compiled in.
REQ-033 Macro VIC_RASTER_IRQ_EN undefined: irq SHALL be constant 0; raster_cmp, irq_en, irq_ack SHALL be ignored; all other behaviour unchanged.

Verification
REQ-034 Reset, then 504 dot_en pulses -> xpos returns to 0, raster=1, line_start high one clk, cycle 63 seen before wrap.
REQ-035 Run 312*504 dot_en pulses -> raster wraps 311->0, frame_start high exactly one clk, line_start high same clk.
REQ-036 dot_en every 8th clk -> phi0 toggles every 4 dot ticks, cycle increments every 8; dot_en=0 for 20 clk holds all outputs.
REQ-037 den=1 at line 0x30, yscroll=3 -> bad_line=1 on lines 0x33,0x3B,...,0xF3, 0 on 0xFB and on lines with den latch clear.
REQ-038 raster_cmp=0x100, irq_en=1 -> irq rises with line_start of line 256; irq_ack pulse clears it; ack coincident with set keeps irq=1; irq_en=0 masks it.
REQ-039 Assert reset at xpos=250, raster=100 with irq=1 -> all outputs at reset values same cycle; build without VIC_RASTER_IRQ_EN -> irq stays 0 in REQ-038 stimulus.
